control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 IR  in  32  instruction register contents; opcode = IR[31:27].
REQ-003 CON  in  1  branch condition flag from the condition logic, valid in the cycle after CONin.
REQ-004 mem_done  in  1  memory handshake; high in any cycle the pending Read/Write completes.
REQ-005 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select and encode strobes for the select/encode stage.
REQ-006 PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin  out  1 each  datapath bus/register strobes.
REQ-007 Read, Write  out  1 each  memory request strobes; alu_op  out  4  ALU operation (0=ADD, 1=SUB, 2=AND, 3=OR); run  out  1  high while executing.

Function
REQ-008 The block SHALL be a Moore FSM: state register updates on the rising clock edge; all outputs are a combinational decode of the current state and IR only.
REQ-009 States SHALL be RESET, T0-T7, HALT; any strobe not listed for a state SHALL be 0 in that state, and alu_op SHALL be 0 except where listed.
REQ-010 RESET: all strobes 0, run=0; next edge -> T0.
REQ-011 Fetch: T0 = PCout, MARin, IncPC -> T1; T1 = Read, MDRin, held until an edge with mem_done=1 -> T2; T2 = MDRout, IRin -> T3.
REQ-012 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, br 10010, jr 10100, nop 11010, halt 11011; any other opcode SHALL behave as nop.
REQ-013 add/sub/and/or: T3 Grb, Rout, Yin; T4 Grc, Rout, Zin, alu_op per op; T5 Zlowout, Gra, Rin -> T0.
REQ-014 addi/andi/ori: T3 Grb, Rout, Yin; T4 Cout, Zin, alu_op ADD/AND/OR; T5 Zlowout, Gra, Rin -> T0.
REQ-015 ldi: T3 Grb, BAout, Yin; T4 Cout, Zin, alu_op=ADD; T5 Zlowout, Gra, Rin -> T0.
REQ-016 ld: T3-T4 as ldi; T5 Zlowout, MARin; T6 Read, MDRin, held until mem_done; T7 MDRout, Gra, Rin -> T0.
REQ-017 st: T3-T4 as ldi; T5 Zlowout, MARin; T6 Gra, Rout, MDRin; T7 Write, held until mem_done -> T0.
REQ-018 br: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, Zin, alu_op=ADD; T6 Zlowout, PCin=CON -> T0.
REQ-019 jr: T3 Gra, Rout, PCin -> T0; nop: T3 no strobes -> T0.
REQ-020 halt: T3 -> HALT; HALT asserts no strobes, run=0, and SHALL remain until reset_n is asserted.
REQ-021 run SHALL be 1 in T0-T7 and 0 in RESET and HALT.
REQ-022 Gra, Grb, Grc SHALL be mutually exclusive in every state; Read and Write SHALL never be simultaneously high.
REQ-023 mem_done SHALL be ignored in every state other than T1, T6 (ld) and T7 (st); a mem_done pulse arriving before the request state is not remembered.
REQ-024 IR SHALL be sampled only via the opcode decode in T3-T7; IR changes during T0-T2 SHALL not affect fetch strobes.

Reset
REQ-025 reset_n low SHALL force state=RESET immediately, regardless of clock, dropping all strobes (including a pending Read/Write) within the same cycle.
REQ-026 Release of reset_n SHALL take effect at the first rising edge with reset_n high, moving RESET -> T0.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction; no partial register write strobe SHALL occur afterwards.

Verification
REQ-028 Reset then fetch with mem_done tied 1: T0 PCout/MARin/IncPC, T1 Read/MDRin, T2 MDRout/IRin on three consecutive cycles.
REQ-029 IR opcode 00011 (add): T3 Grb+Rout+Yin, T4 Grc+Rout+Zin alu_op=0, T5 Zlowout+Gra+Rin, back to T0; 6 cycles total.
REQ-030 ld with mem_done low for 3 cycles in T6: Read/MDRin held 4 cycles, T7 Gra+Rin once, total 11 cycles.
REQ-031 br with CON=0 then CON=1: PCin=0 in T6 for first, PCin=1 in T6 for second.
REQ-032 opcode 11011 (halt): run falls after T3, all strobes 0 for 20 cycles; reset_n pulse returns run=1 and T0.
REQ-033 reset_n asserted during st T7 with Write high: Write drops asynchronously, no strobe until T0 after release.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing fetch/execute datapath strobes decoded from IR opcode
module control_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_done,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
  output logic        Yin, Zin, Zlowout, Cout, CONin,
  output logic        Read, Write,
  output logic [3:0]  alu_op,
  output logic        run
);
  typedef enum logic [3:0] {S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;
  state_t state, state_next;
  logic [4:0] op;
  logic is_rr, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_halt, is_mem, is_addr;
  logic [3:0] op_alu;
  logic unused_ir;
  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_rr     = op inside {5'b00011, 5'b00100, 5'b01001, 5'b01010};
  assign is_imm    = op inside {5'b01011, 5'b01100, 5'b01101};
  assign is_ldi    = op == 5'b00001;
  assign is_ld     = op == 5'b00000;
  assign is_st     = op == 5'b00010;
  assign is_br     = op == 5'b10010;
  assign is_jr     = op == 5'b10100;
  assign is_halt   = op == 5'b11011;
  assign is_mem    = is_ld | is_st;
  assign is_addr   = is_ldi | is_mem;
  assign op_alu    = (op == 5'b00100) ? 4'd1 :
                     (op inside {5'b01001, 5'b01100}) ? 4'd2 :
                     (op inside {5'b01010, 5'b01101}) ? 4'd3 : 4'd0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= S_RESET;
    else          state <= state_next;
  always_comb begin
    state_next = state;
    {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin} = '0;
    {MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write} = '0;
    alu_op = 4'd0;
    run    = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_RESET: state_next = S_T0;
      S_T0: begin
        {PCout, MARin, IncPC} = 3'b111;
        state_next = S_T1;
      end
      S_T1: begin
        {Read, MDRin} = 2'b11;
        state_next = mem_done ? S_T2 : S_T1;
      end
      S_T2: begin
        {MDRout, IRin} = 2'b11;
        state_next = S_T3;
      end
      S_T3: begin
        Grb   = is_rr | is_imm | is_addr;
        Gra   = is_br | is_jr;
        Rout  = is_rr | is_imm | is_br | is_jr;
        BAout = is_addr;
        Yin   = is_rr | is_imm | is_addr;
        CONin = is_br;
        PCin  = is_jr;
        state_next = is_halt ? S_HALT : (is_rr | is_imm | is_addr | is_br) ? S_T4 : S_T0;
      end
      S_T4: begin
        Grc    = is_rr;
        Rout   = is_rr;
        Cout   = is_imm | is_addr;
        Zin    = is_rr | is_imm | is_addr;
        alu_op = (is_rr | is_imm) ? op_alu : 4'd0;
        PCout  = is_br;
        Yin    = is_br;
        state_next = S_T5;
      end
      S_T5: begin
        Zlowout = is_rr | is_imm | is_addr;
        Gra     = is_rr | is_imm | is_ldi;
        Rin     = is_rr | is_imm | is_ldi;
        MARin   = is_mem;
        Cout    = is_br;
        Zin     = is_br;
        state_next = (is_mem | is_br) ? S_T6 : S_T0;
      end
      S_T6: begin
        Read    = is_ld;
        MDRin   = is_ld | is_st;
        Gra     = is_st;
        Rout    = is_st;
        Zlowout = is_br;
        PCin    = is_br & CON;
        state_next = is_ld ? (mem_done ? S_T7 : S_T6) : is_st ? S_T7 : S_T0;
      end
      S_T7: begin
        MDRout = is_ld;
        Gra    = is_ld;
        Rin    = is_ld;
        Write  = is_st;
        state_next = (is_st && !mem_done) ? S_T7 : S_T0;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction micro-step table model, directed pins plus random stimulus
module tb_control_sequencer;
  logic clock = 0, reset_n = 1, CON = 0, mem_done = 0;
  logic [31:0] IR = 0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Cout, CONin, Read, Write, run;
  logic [3:0] alu_op;
  logic [19:0] act;
  int checks = 0, errors = 0, tcount = 0;
  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON(CON), .mem_done(mem_done),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );
  always #5 clock = ~clock;
  assign act = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write};
  localparam logic [19:0] GRA = 20'h80000, GRB = 20'h40000, GRC = 20'h20000, RIN = 20'h10000,
    ROUT = 20'h08000, BAOUT = 20'h04000, PCOUT = 20'h02000, PCIN = 20'h01000, INCPC = 20'h00800,
    MARIN = 20'h00400, MDRIN = 20'h00200, MDROUT = 20'h00100, IRIN = 20'h00080, YIN = 20'h00040,
    ZIN = 20'h00020, ZLOWOUT = 20'h00010, COUT = 20'h00008, CONIN = 20'h00004, READ = 20'h00002,
    WRITE = 20'h00001;
  localparam logic [4:0] OPS [14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01001,
    5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b10010, 5'b10100, 5'b11010, 5'b11011};
  typedef struct packed {logic [19:0] s; logic [3:0] alu; logic wm; logic con;} step_t;
  function automatic step_t mk(input logic [19:0] s, input logic [3:0] a = 4'd0,
                               input logic w = 1'b0, input logic c = 1'b0);
    return '{s, a, w, c};
  endfunction
  // Full micro-step program of one instruction: the three fetch steps then the execute steps
  function automatic int build(input logic [4:0] op, output step_t p [8]);
    logic [3:0] a;
    for (int i = 0; i < 8; i++) p[i] = mk(20'h0);
    p[0] = mk(PCOUT | MARIN | INCPC);
    p[1] = mk(READ | MDRIN, 4'd0, 1'b1);
    p[2] = mk(MDROUT | IRIN);
    a = (op == 5'b00100) ? 4'd1 : (op == 5'b01001 || op == 5'b01100) ? 4'd2 :
        (op == 5'b01010 || op == 5'b01101) ? 4'd3 : 4'd0;
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        p[3] = mk(GRB | ROUT | YIN); p[4] = mk(GRC | ROUT | ZIN, a); p[5] = mk(ZLOWOUT | GRA | RIN);
        return 6;
      end
      5'b01011, 5'b01100, 5'b01101: begin
        p[3] = mk(GRB | ROUT | YIN); p[4] = mk(COUT | ZIN, a); p[5] = mk(ZLOWOUT | GRA | RIN);
        return 6;
      end
      5'b00001: begin
        p[3] = mk(GRB | BAOUT | YIN); p[4] = mk(COUT | ZIN); p[5] = mk(ZLOWOUT | GRA | RIN);
        return 6;
      end
      5'b00000: begin
        p[3] = mk(GRB | BAOUT | YIN); p[4] = mk(COUT | ZIN); p[5] = mk(ZLOWOUT | MARIN);
        p[6] = mk(READ | MDRIN, 4'd0, 1'b1); p[7] = mk(MDROUT | GRA | RIN);
        return 8;
      end
      5'b00010: begin
        p[3] = mk(GRB | BAOUT | YIN); p[4] = mk(COUT | ZIN); p[5] = mk(ZLOWOUT | MARIN);
        p[6] = mk(GRA | ROUT | MDRIN); p[7] = mk(WRITE, 4'd0, 1'b1);
        return 8;
      end
      5'b10010: begin
        p[3] = mk(GRA | ROUT | CONIN); p[4] = mk(PCOUT | YIN); p[5] = mk(COUT | ZIN);
        p[6] = mk(ZLOWOUT, 4'd0, 1'b0, 1'b1);
        return 7;
      end
      5'b10100: begin
        p[3] = mk(GRA | ROUT | PCIN);
        return 4;
      end
      default: return 4;
    endcase
  endfunction
  function automatic step_t step_at(input logic [4:0] op, input int k);
    step_t p [8];
    void'(build(op, p));
    return p[k];
  endfunction
  function automatic int plen(input logic [4:0] op);
    step_t p [8];
    return build(op, p);
  endfunction
  // Model: mode 0 = reset, 1 = running step idx of the current program, 2 = halted
  int mode = 0, idx = 0;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mode <= 0;
      idx  <= 0;
    end else if (mode == 0) begin
      mode <= 1;
      idx  <= 0;
    end else if (mode == 1) begin
      if (!(step_at(IR[31:27], idx).wm && !mem_done)) begin
        if (idx == plen(IR[31:27]) - 1) begin
          idx <= 0;
          if (IR[31:27] == 5'b11011) mode <= 2;
        end else idx <= idx + 1;
      end
    end
  function automatic logic [24:0] expected();
    step_t s;
    if (mode != 1) return 25'h0;
    s = step_at(IR[31:27], idx);
    return {s.s | ((s.con && CON) ? PCIN : 20'h0), s.alu, 1'b1};
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
    end
  endtask
  always @(negedge clock) begin
    chk("model", 64'({act, alu_op, run}), 64'(expected()));
    chk("exclusive", 64'(($countones({Gra, Grb, Grc}) <= 1) && !(Read && Write)), 64'd1);
  end
  task automatic tick();
    @(posedge clock);
    #1;
    tcount++;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  function automatic logic [4:0] pick_op();
    int r;
    r = $urandom_range(0, 14);
    return (r == 14) ? 5'($urandom) : OPS[r];
  endfunction
  int t0;
  initial begin
    IR = {5'b00011, 27'h0};
    mem_done = 1;
    #1 reset_n = 0;
    tick();
    chk("reset_run", 64'(run), 64'd0);
    chk("reset_strobes", 64'(act), 64'd0);
    reset_n = 1;
    tick();
    t0 = tcount;
    chk("fetch_t0", 64'(act), 64'(PCOUT | MARIN | INCPC));
    tick();
    chk("fetch_t1", 64'(act), 64'(READ | MDRIN));
    tick();
    chk("fetch_t2", 64'(act), 64'(MDROUT | IRIN));
    tick();
    chk("add_t3", 64'(act), 64'(GRB | ROUT | YIN));
    tick();
    chk("add_t4", 64'({act, alu_op}), 64'({GRC | ROUT | ZIN, 4'd0}));
    tick();
    chk("add_t5", 64'(act), 64'(ZLOWOUT | GRA | RIN));
    tick();
    chk("add_back_t0", 64'(act), 64'(PCOUT | MARIN | INCPC));
    chk("add_cycles", 64'(tcount - t0), 64'd6);
    IR = {5'b00000, 27'h0};
    t0 = tcount;
    ticks(6);
    mem_done = 0;
    for (int i = 0; i < 4; i++) begin
      chk("ld_t6_read", 64'(act), 64'(READ | MDRIN));
      mem_done = (i == 3);
      tick();
    end
    chk("ld_t7", 64'(act), 64'(MDROUT | GRA | RIN));
    tick();
    chk("ld_back_t0", 64'(act), 64'(PCOUT | MARIN | INCPC));
    chk("ld_cycles", 64'(tcount - t0), 64'd11);
    for (int c = 0; c < 2; c++) begin
      IR = {5'b10010, 27'h0};
      CON = c[0];
      ticks(6);
      chk("br_t6_pcin", 64'(act), 64'(ZLOWOUT | (c == 1 ? PCIN : 20'h0)));
      tick();
    end
    IR = {5'b11011, 27'h0};
    ticks(3);
    chk("halt_t3_run", 64'(run), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_idle", 64'({act, alu_op, run}), 64'd0);
    end
    reset_n = 0;
    #2 reset_n = 1;
    tick();
    chk("halt_reset_t0", 64'({act, run}), 64'({PCOUT | MARIN | INCPC, 1'b1}));
    IR = {5'b00010, 27'h0};
    mem_done = 1;
    ticks(6);
    mem_done = 0;
    tick();
    chk("st_t7_write", 64'(act), 64'(WRITE));
    #2 reset_n = 0;
    #1 chk("st_async_drop", 64'({act, run}), 64'd0);
    ticks(2);
    chk("reset_quiet", 64'({act, run}), 64'd0);
    reset_n = 1;
    mem_done = 1;
    tick();
    chk("st_reset_t0", 64'(act), 64'(PCOUT | MARIN | INCPC));
    for (int c = 0; c < 4000; c++) begin
      mem_done = $urandom_range(0, 2) != 0;
      CON = 1'($urandom_range(0, 1));
      if (mode != 1 || idx < 3) IR = {pick_op(), 27'($urandom)};
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 149) == 0 || (mode == 2 && $urandom_range(0, 7) == 0)) #2 reset_n = 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
